// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF/LSU) and memory-side signals around mem_port_arbiter.
// slave is the arbiter's view; master is the surrounding pipeline plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch requester
  logic                  i_if_req;
  logic [ADDR_W-1:0]     i_if_addr;
  logic                  i_flush;
  logic [DATA_W-1:0]     o_if_rdata;
  logic                  o_if_valid;
  logic                  o_if_stall;
  // Load/store requester
  logic                  i_lsu_req;
  logic                  i_lsu_we;
  logic [ADDR_W-1:0]     i_lsu_addr;
  logic [DATA_W-1:0]     i_lsu_wdata;
  logic [DATA_W/8-1:0]   i_lsu_bmask;
  logic [DATA_W-1:0]     o_lsu_rdata;
  logic                  o_lsu_valid;
  logic                  o_lsu_stall;
  // Memory side
  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_W-1:0]     o_mem_wdata;
  logic [DATA_W/8-1:0]   o_mem_bmask;
  logic                  i_mem_ack;
  logic [DATA_W-1:0]     i_mem_rdata;
  logic                  o_bus_err;

  modport slave (
    input  i_if_req, i_if_addr, i_flush,
    output o_if_rdata, o_if_valid, o_if_stall,
    input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
    output o_lsu_rdata, o_lsu_valid, o_lsu_stall,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    input  i_mem_ack, i_mem_rdata,
    output o_bus_err
  );

  modport master (
    output i_if_req, i_if_addr, i_flush,
    input  o_if_rdata, o_if_valid, o_if_stall,
    output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
    input  o_lsu_rdata, o_lsu_valid, o_lsu_stall,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    output i_mem_ack, i_mem_rdata,
    input  o_bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and the LSU,
// with starvation bound on fetch, branch-flush abort and a memory-hang timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int BM_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BM_W-1:0]     mem_bmask_q, mem_bmask_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                lsu_valid_q, lsu_valid_d;
  logic                bus_err_q, bus_err_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                abort_q, abort_d;

  logic if_elig, lsu_elig, grant_if, grant_lsu, aborted, timed_out;

  // A requester whose completion pulse is showing this cycle has not yet seen it,
  // so it cannot be re-granted on the stale level request.
  assign if_elig   = bus.i_if_req & ~if_valid_q & ~bus.i_flush;
  assign lsu_elig  = bus.i_lsu_req & ~lsu_valid_q;
  assign grant_if  = if_elig & (~lsu_elig | (starve_q == STARVE_TOP));
  assign grant_lsu = lsu_elig & ~grant_if;
  assign aborted   = abort_q | bus.i_flush;
  assign timed_out = (tmo_q == TMO_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    lsu_rdata_d = lsu_rdata_q;
    lsu_valid_d = 1'b0;
    bus_err_d   = 1'b0;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    abort_d     = abort_q;

    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_if_addr;
          mem_bmask_d = '0;
          starve_d    = '0;
          tmo_d       = '0;
          abort_d     = 1'b0;
        end else if (grant_lsu) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.i_lsu_we;
          mem_addr_d  = bus.i_lsu_addr;
          mem_wdata_d = bus.i_lsu_wdata;
          mem_bmask_d = bus.i_lsu_bmask;
          tmo_d       = '0;
          if (bus.i_if_req && (starve_q != STARVE_TOP))
            starve_d = starve_q + SW'(1);
        end
      end

      FETCH: begin
        if (bus.i_mem_ack || timed_out) begin
          // An ack coinciding with the timeout is a normal completion.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          abort_d   = 1'b0;
          bus_err_d = ~bus.i_mem_ack;
          if (!aborted) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.i_mem_ack ? bus.i_mem_rdata : '0;
          end
        end else begin
          tmo_d   = tmo_q + TW'(1);
          abort_d = aborted;
        end
      end

      DATA: begin
        if (bus.i_mem_ack || timed_out) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          lsu_valid_d = 1'b1;
          bus_err_d   = ~bus.i_mem_ack;
          if (!mem_we_q)
            lsu_rdata_d = bus.i_mem_ack ? bus.i_mem_rdata : '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_valid_q <= lsu_valid_d;
      bus_err_q   <= bus_err_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_bmask = mem_bmask_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_if_valid  = if_valid_q;
  assign bus.o_lsu_rdata = lsu_rdata_q;
  assign bus.o_lsu_valid = lsu_valid_q;
  assign bus.o_bus_err   = bus_err_q;
  assign bus.o_if_stall  = bus.i_if_req & ~if_valid_q;
  assign bus.o_lsu_stall = bus.i_lsu_req & ~lsu_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, priority, starvation, flush, timeout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic clk;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_if_req    = 1'b0;
    bus.i_if_addr   = '0;
    bus.i_flush     = 1'b0;
    bus.i_lsu_req   = 1'b0;
    bus.i_lsu_we    = 1'b0;
    bus.i_lsu_addr  = '0;
    bus.i_lsu_wdata = '0;
    bus.i_lsu_bmask = '0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of sequence, expected $finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();

    // Reset state
    check("rst_mem_req",   bus.o_mem_req,   1'b0);
    check("rst_if_valid",  bus.o_if_valid,  1'b0);
    check("rst_lsu_valid", bus.o_lsu_valid, 1'b0);
    check("rst_bus_err",   bus.o_bus_err,   1'b0);
    check("rst_if_stall",  bus.o_if_stall,  1'b0);
    check("rst_lsu_stall", bus.o_lsu_stall, 1'b0);
    check("rst_mem_addr",  bus.o_mem_addr,  32'h0);
    check("rst_starve",    dut.starve_q,    3'd0);
    rst_n = 1'b1;
    tick();

    // Single zero-wait fetch
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h100;
    #1 check("t2_if_stall", bus.o_if_stall, 1'b1);
    tick();
    check("t2_mem_req",   bus.o_mem_req,   1'b1);
    check("t2_mem_addr",  bus.o_mem_addr,  32'h100);
    check("t2_mem_we",    bus.o_mem_we,    1'b0);
    check("t2_mem_bmask", bus.o_mem_bmask, 4'h0);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0000_0013;
    tick();
    check("t2_if_valid",  bus.o_if_valid,  1'b1);
    check("t2_if_rdata",  bus.o_if_rdata,  32'h13);
    check("t2_req_drop",  bus.o_mem_req,   1'b0);
    check("t2_stall_off", bus.o_if_stall,  1'b0);
    bus.i_mem_ack = 1'b0;
    bus.i_if_req  = 1'b0;
    tick();
    check("t2_valid_pulse", bus.o_if_valid, 1'b0);

    // Simultaneous load and fetch: LSU first, fetch right after
    bus.i_lsu_req  = 1'b1;
    bus.i_lsu_we   = 1'b0;
    bus.i_lsu_addr = 32'h2000;
    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 32'h104;
    tick();
    check("t3_lsu_first",  bus.o_mem_addr, 32'h2000);
    check("t3_load_we",    bus.o_mem_we,   1'b0);
    check("t3_if_stall_a", bus.o_if_stall, 1'b1);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("t3_lsu_valid",  bus.o_lsu_valid, 1'b1);
    check("t3_lsu_rdata",  bus.o_lsu_rdata, 32'hDEAD_BEEF);
    check("t3_if_stall_b", bus.o_if_stall,  1'b1);
    bus.i_mem_ack = 1'b0;
    bus.i_lsu_req = 1'b0;
    tick();
    check("t3_fetch_req",  bus.o_mem_req,  1'b1);
    check("t3_fetch_addr", bus.o_mem_addr, 32'h104);
    check("t3_if_stall_c", bus.o_if_stall, 1'b1);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0040_0093;
    tick();
    check("t3_if_valid", bus.o_if_valid, 1'b1);
    check("t3_if_rdata", bus.o_if_rdata, 32'h0040_0093);
    bus.i_mem_ack = 1'b0;
    bus.i_if_req  = 1'b0;
    tick();

    // Starvation: flush keeps fetch ineligible while four stores are granted
    bus.i_if_req    = 1'b1;
    bus.i_if_addr   = 32'h300;
    bus.i_flush     = 1'b1;
    bus.i_lsu_req   = 1'b1;
    bus.i_lsu_we    = 1'b1;
    bus.i_lsu_bmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.i_lsu_addr  = 32'h3000 + 32'(4 * i);
      bus.i_lsu_wdata = 32'hA5A5_0000 + 32'(i);
      tick();
      check($sformatf("t4_st%0d_addr", i),  bus.o_mem_addr,  32'h3000 + 32'(4 * i));
      check($sformatf("t4_st%0d_we", i),    bus.o_mem_we,    1'b1);
      check($sformatf("t4_st%0d_wdata", i), bus.o_mem_wdata, 32'hA5A5_0000 + 32'(i));
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'hFFFF_FFFF;
      tick();
      check($sformatf("t4_st%0d_valid", i), bus.o_lsu_valid, 1'b1);
      check($sformatf("t4_st%0d_rdata", i), bus.o_lsu_rdata, 32'hDEAD_BEEF);
      bus.i_mem_ack = 1'b0;
      tick();
    end
    check("t4_starve_full", dut.starve_q, 3'd4);
    bus.i_flush = 1'b0;
    tick();
    check("t4_fetch_wins", bus.o_mem_addr,  32'h300);
    check("t4_fetch_we",   bus.o_mem_we,    1'b0);
    check("t4_fetch_bm",   bus.o_mem_bmask, 4'h0);
    check("t4_starve_clr", dut.starve_q,    3'd0);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0000_0517;
    tick();
    check("t4_if_valid",  bus.o_if_valid,  1'b1);
    check("t4_lsu_stall", bus.o_lsu_stall, 1'b1);
    bus.i_mem_ack = 1'b0;
    bus.i_if_req  = 1'b0;
    bus.i_lsu_req = 1'b0;
    tick();

    // Flush of an outstanding fetch
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h180;
    tick();
    check("t5_fetch_addr", bus.o_mem_addr, 32'h180);
    bus.i_flush   = 1'b1;
    bus.i_if_addr = 32'h200;
    tick();
    check("t5_req_held", bus.o_mem_req, 1'b1);
    bus.i_flush = 1'b0;
    tick(); tick();
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0000_0BAD;
    tick();
    check("t5_no_valid",  bus.o_if_valid, 1'b0);
    check("t5_rdata_kept", bus.o_if_rdata, 32'h0000_0517);
    check("t5_req_drop",  bus.o_mem_req,  1'b0);
    bus.i_mem_ack = 1'b0;
    tick();
    check("t5_new_req",  bus.o_mem_req,  1'b1);
    check("t5_new_addr", bus.o_mem_addr, 32'h200);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0000_0297;
    tick();
    check("t5_new_valid", bus.o_if_valid, 1'b1);
    check("t5_new_rdata", bus.o_if_rdata, 32'h0000_0297);
    bus.i_mem_ack = 1'b0;
    bus.i_if_req  = 1'b0;
    tick();

    // Timeout of a store that is never acknowledged
    bus.i_lsu_req   = 1'b1;
    bus.i_lsu_we    = 1'b1;
    bus.i_lsu_addr  = 32'h4000;
    bus.i_lsu_wdata = 32'h1234_5678;
    bus.i_lsu_bmask = 4'h3;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check($sformatf("t6_req_c%0d", i),   bus.o_mem_req,   1'b1);
      check($sformatf("t6_noerr_c%0d", i), bus.o_bus_err,   1'b0);
    end
    tick();
    check("t6_req_drop",  bus.o_mem_req,   1'b0);
    check("t6_bus_err",   bus.o_bus_err,   1'b1);
    check("t6_lsu_valid", bus.o_lsu_valid, 1'b1);
    bus.i_lsu_req   = 1'b0;
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h5555_5555;
    tick();
    check("t6_err_pulse",   bus.o_bus_err,   1'b0);
    check("t6_stray_valid", bus.o_lsu_valid, 1'b0);
    check("t6_stray_req",   bus.o_mem_req,   1'b0);
    bus.i_mem_ack = 1'b0;
    tick();

    // Reset asserted in the middle of a load
    bus.i_lsu_req  = 1'b1;
    bus.i_lsu_we   = 1'b0;
    bus.i_lsu_addr = 32'h5000;
    tick();
    check("t1_req_before", bus.o_mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_req_async",  bus.o_mem_req,   1'b0);
    check("t1_addr_clr",   bus.o_mem_addr,  32'h0);
    check("t1_if_rdata",   bus.o_if_rdata,  32'h0);
    check("t1_lsu_rdata",  bus.o_lsu_rdata, 32'h0);
    check("t1_lsu_valid",  bus.o_lsu_valid, 1'b0);
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t1_idle",       dut.state_q,     2'd0);
    check("t1_req_after",  bus.o_mem_req,   1'b0);
    check("t1_no_valid",   bus.o_lsu_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
